// File: rtl/mtm_alu_out_deserializer.sv
// Serial-to-parallel receiver for the ALU result stream: collects framed bytes
// into a DATA_BYTES-wide result plus control byte and flags framing/protocol errors.
module mtm_alu_out_deserializer #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sin,
    output logic [8*DATA_BYTES-1:0] C_out,
    output logic [7:0]              CTL_out,
    output logic                    out_valid,
    output logic                    out_is_err,
    output logic                    frame_err,
    output logic                    proto_err
);

    localparam int C_W   = 8 * DATA_BYTES;
    localparam int CNT_W = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PKT,
        S_DATA,
        S_STOP,
        S_RESYNC
    } state_t;

    state_t           state, state_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic             is_ctl, is_ctl_n;
    logic [7:0]       shift, shift_n;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_n;
    logic [C_W-1:0]   c_buf, c_buf_n;
    logic [C_W-1:0]   c_out_n;
    logic [7:0]       ctl_out_n;
    logic             out_valid_n, out_is_err_n, frame_err_n, proto_err_n;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        is_ctl_n     = is_ctl;
        shift_n      = shift;
        byte_cnt_n   = byte_cnt;
        c_buf_n      = c_buf;
        c_out_n      = C_out;
        ctl_out_n    = CTL_out;
        out_is_err_n = out_is_err;
        out_valid_n  = 1'b0;
        frame_err_n  = 1'b0;
        proto_err_n  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!sin) state_n = S_PKT;
            end
            S_PKT: begin
                is_ctl_n  = sin;
                bit_cnt_n = 3'd0;
                state_n   = S_DATA;
            end
            S_DATA: begin
                shift_n   = {shift[6:0], sin};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = S_STOP;
            end
            S_STOP: begin
                if (sin) begin
                    state_n = S_IDLE;
                    if (!is_ctl) begin
                        if (byte_cnt == FULL) begin
                            proto_err_n = 1'b1;
                            byte_cnt_n  = '0;
                        end else begin
                            c_buf_n    = (c_buf << 8) | C_W'(shift);
                            byte_cnt_n = byte_cnt + 1'b1;
                        end
                    end else if (byte_cnt == FULL) begin
                        c_out_n      = c_buf;
                        ctl_out_n    = shift;
                        out_valid_n  = 1'b1;
                        out_is_err_n = 1'b0;
                        byte_cnt_n   = '0;
                    end else if (byte_cnt == '0) begin
                        // A lone control frame is the ALU's error report.
                        c_out_n      = '0;
                        ctl_out_n    = shift;
                        out_valid_n  = 1'b1;
                        out_is_err_n = 1'b1;
                    end else begin
                        proto_err_n = 1'b1;
                        byte_cnt_n  = '0;
                    end
                end else begin
                    // Bad stop bit: drop the packet and wait for the line to return high
                    // so a stuck-low line is not taken as a new start bit.
                    frame_err_n = 1'b1;
                    byte_cnt_n  = '0;
                    state_n     = S_RESYNC;
                end
            end
            S_RESYNC: begin
                if (sin) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            is_ctl     <= 1'b0;
            shift      <= 8'd0;
            byte_cnt   <= '0;
            c_buf      <= '0;
            C_out      <= '0;
            CTL_out    <= 8'd0;
            out_valid  <= 1'b0;
            out_is_err <= 1'b0;
            frame_err  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            is_ctl     <= is_ctl_n;
            shift      <= shift_n;
            byte_cnt   <= byte_cnt_n;
            c_buf      <= c_buf_n;
            C_out      <= c_out_n;
            CTL_out    <= ctl_out_n;
            out_valid  <= out_valid_n;
            out_is_err <= out_is_err_n;
            frame_err  <= frame_err_n;
            proto_err  <= proto_err_n;
        end
    end

endmodule

// File: tb/tb_mtm_alu_out_deserializer.sv
// Scoreboard bench: the driver pushes expected events (with their cycle) as it
// sends frames; a monitor pops and compares whenever the DUT pulses an output.
module tb_mtm_alu_out_deserializer;

    localparam int KIND_VALID = 0;
    localparam int KIND_FRAME = 1;
    localparam int KIND_PROTO = 2;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic [31:0] C_out;
    logic [7:0]  CTL_out;
    logic        out_valid, out_is_err, frame_err, proto_err;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] c;
        logic [7:0]  ctl;
        logic        is_err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   valid_cycles[$];

    mtm_alu_out_deserializer #(.DATA_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .C_out     (C_out),
        .CTL_out   (CTL_out),
        .out_valid (out_valid),
        .out_is_err(out_is_err),
        .frame_err (frame_err),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    // The bit driven now is sampled by the next rising edge, i.e. cycle cyc+1.
    task automatic send_frame(input logic ctl_bit, input logic [7:0] b,
                              input logic stop_bit, output int stop_cyc);
        drive_bit(1'b0);
        drive_bit(ctl_bit);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        drive_bit(stop_bit);
        stop_cyc = cyc + 1;
    endtask

    task automatic push(input int kind, input logic [31:0] c, input logic [7:0] ctl,
                        input logic is_err, input int at);
        exp_t e;
        e.kind = kind; e.c = c; e.ctl = ctl; e.is_err = is_err; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic send_data(input logic [7:0] b);
        int sc;
        send_frame(1'b0, b, 1'b1, sc);
    endtask

    task automatic send_packet(input logic [31:0] c, input logic [7:0] ctl);
        int sc;
        for (int i = 0; i < 4; i++) send_frame(1'b0, c[8*(3-i) +: 8], 1'b1, sc);
        send_frame(1'b1, ctl, 1'b1, sc);
        push(KIND_VALID, c, ctl, 1'b0, sc);
    endtask

    task automatic send_err_packet(input logic [7:0] ctl);
        int sc;
        send_frame(1'b1, ctl, 1'b1, sc);
        push(KIND_VALID, 32'h0, ctl, 1'b1, sc);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [31:0] hold_c;
        logic [7:0]  hold_ctl;
        logic        hold_err;
        logic        rst_seen;
        logic [2:0]  pulses;
        int          kind;
        exp_t        e;
        hold_c = '0; hold_ctl = '0; hold_err = 1'b0;
        forever begin
            @(posedge clk);
            rst_seen = !rst_n;
            #1;
            if (rst_seen) begin
                check("reset_outputs",
                      {C_out, CTL_out, out_valid, out_is_err, frame_err, proto_err}, '0);
                hold_c = '0; hold_ctl = '0; hold_err = 1'b0;
                continue;
            end
            pulses = {out_valid, frame_err, proto_err};
            if (pulses != 3'b000) begin
                check("pulse_exclusive", 64'($countones(pulses)), 64'd1);
                kind = out_valid ? KIND_VALID : (frame_err ? KIND_FRAME : KIND_PROTO);
                if (sb.size() == 0) begin
                    check("unexpected_pulse_kind", 64'(kind), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", 64'(kind), 64'(e.kind));
                    check("event_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.kind == KIND_VALID) begin
                        check("C_out", C_out, e.c);
                        check("CTL_out", CTL_out, e.ctl);
                        check("out_is_err", out_is_err, e.is_err);
                        hold_c = e.c; hold_ctl = e.ctl; hold_err = e.is_err;
                        valid_cycles.push_back(cyc);
                    end
                end
            end
            if (!out_valid) begin
                check("hold_C_out", C_out, hold_c);
                check("hold_CTL_out", CTL_out, hold_ctl);
                check("hold_out_is_err", out_is_err, hold_err);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int sc;
        int n;
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // 1: full data packet
        send_packet(32'hDEADBEEF, 8'h0A);
        idle(5);

        // 2: single-control error packets
        send_err_packet(8'hC9);
        idle(3);
        send_err_packet(8'h93);
        idle(2);
        send_err_packet(8'hA5);
        idle(3);

        // 3: framing error on 2nd data frame, line held low, then a valid packet
        send_data(8'hAB);
        send_frame(1'b0, 8'hCD, 1'b0, sc);
        push(KIND_FRAME, '0, '0, 1'b0, sc);
        repeat (4) drive_bit(1'b0);
        idle(2);
        send_packet(32'h12345678, 8'h05);
        idle(3);

        // 4a: control frame after two data frames, then a valid packet
        send_data(8'h11);
        send_data(8'h22);
        send_frame(1'b1, 8'h33, 1'b1, sc);
        push(KIND_PROTO, '0, '0, 1'b0, sc);
        idle(2);
        send_packet(32'hCAFEF00D, 8'h3C);
        idle(2);

        // 4b: five data frames in a row
        for (int i = 0; i < 4; i++) send_data(8'h40 + 8'(i));
        send_frame(1'b0, 8'h44, 1'b1, sc);
        push(KIND_PROTO, '0, '0, 1'b0, sc);
        idle(2);
        send_packet(32'h00000001, 8'h80);
        idle(2);

        // 5: reset during the 3rd data frame, then a fresh packet
        send_data(8'h01);
        send_data(8'h02);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        sin   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_packet(32'hFFFFFFFF, 8'h7F);
        idle(3);

        // 6: three packets back to back, single-control packet in the middle
        send_packet(32'hA5A55A5A, 8'h11);
        send_err_packet(8'h93);
        send_packet(32'h0BADF00D, 8'h22);
        idle(5);
        n = valid_cycles.size();
        if (n >= 3) begin
            check("stream_gap_err", 64'(valid_cycles[n-2] - valid_cycles[n-3]), 64'd11);
            check("stream_gap_data", 64'(valid_cycles[n-1] - valid_cycles[n-2]), 64'd55);
        end else begin
            check("stream_valid_count", 64'(n), 64'd3);
        end

        idle(10);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mtm_alu_out_deserializer.md
Name: mtm_alu_out_deserializer

Overview:
Receives the ALU result serial stream (one bit per clk, no oversampling) and reassembles it into a 32-bit result plus control byte. It is the receiving end of the serializer's framing, used as the output checker/monitor path and as the link partner in loopback tests. Each frame carries one byte, and frames are assembled into packets. The block reports complete packets, single-control (error) packets, and framing and protocol violations.

Parameters:
DATA_BYTES, 4, data frames expected before the CTL frame; C_out width = 8*DATA_BYTES.

Ports:
clk  in  1  rising-edge clock; one serial bit per cycle
rst_n  in  1  synchronous active-low reset
sin  in  1  serial input; idles high
C_out  out  8*DATA_BYTES  assembled result; first received byte lands in MSB byte
CTL_out  out  8  control byte of the packet
out_valid  out  1  one-cycle pulse; C_out/CTL_out valid while high
out_is_err  out  1  qualifies out_valid: 1 = single-CTL-frame packet (C_out = 0)
frame_err  out  1  one-cycle pulse: stop bit sampled 0
proto_err  out  1  one-cycle pulse: illegal frame sequence

Behaviour:
- Reset (rst_n=0 at edge):
  - State goes to IDLE; byte count = 0; shift and C buffers cleared.
  - All outputs go to 0: C_out, CTL_out, out_valid, out_is_err, frame_err, proto_err.
  - Reset mid-frame discards the partial packet.
- Frame = start(0), packet bit (0 = data, 1 = ctl), 8 data bits MSB first, stop(1). That is 11 cycles.
- Back-to-back frames with no idle gap must be accepted. The cycle after a stop bit may be a start bit.
- FSM states and transitions:
  - IDLE: sin=0 -> PKT; otherwise stay.
  - PKT: latch packet bit; bit counter = 0 -> DATA.
  - DATA: shift sin into shift reg LSB; after 8th bit -> STOP.
  - STOP: sin=1 -> process frame, -> IDLE. sin=0 -> frame_err pulse, discard packet (byte count = 0) -> RESYNC.
  - RESYNC: wait for sin=1, then -> IDLE. This prevents a stuck-low line from being read as a start bit.
- Frame processing, done at the edge sampling a valid stop bit:
  - Data frame, count < DATA_BYTES: C buffer = {C buffer[8*DATA_BYTES-9:0], byte}; count++.
  - Data frame, count == DATA_BYTES: proto_err pulse; packet discarded; count = 0.
  - Ctl frame, count == DATA_BYTES: C_out = C buffer, CTL_out = byte, out_valid=1, out_is_err=0; count = 0.
  - Ctl frame, count == 0: C_out = 0, CTL_out = byte, out_valid=1, out_is_err=1.
  - Ctl frame, 0 < count < DATA_BYTES: proto_err pulse; discard; count = 0.
- Latency: out_valid, frame_err and proto_err are registered on the same edge that samples the deciding stop bit. They are high for exactly one cycle.
- C_out/CTL_out hold their values until the next out_valid or reset. out_is_err holds with them.
- out_valid, frame_err and proto_err are mutually exclusive in any cycle.
- CTL contents are passed through unchecked (no CRC or flag decode in this block).
- Minimum packet length (DATA_BYTES=4): 55 cycles. Single-CTL packet: 11 cycles.

Test Plan:
1. Data packet: C=0xDEADBEEF, CTL=0x0A, five frames back-to-back with sin=1 before and after. Required: out_valid high exactly once, on the edge of the 55th bit; C_out=0xDEADBEEF; CTL_out=0x0A; out_is_err=0; no err pulses.
2. Error packet: single ctl frame with byte 0xC9 (and separately 0x93 and 0xA5). Required: out_valid=1 and out_is_err=1 on the 11th bit; CTL_out=0xC9; C_out=0.
3. Framing error: stop bit of 2nd data frame driven 0, held low 5 cycles, then a full valid packet C=0x12345678, CTL=0x05. Required: frame_err pulse once, no spurious start detected while low, then out_valid with C_out=0x12345678.
4. Protocol errors, two cases:
   - Ctl frame after 2 data frames: proto_err pulse and no out_valid. A following valid packet is decoded correctly.
   - 5 data frames: proto_err on the 5th stop bit.
5. Reset mid-operation: assert rst_n=0 for 1 cycle during the 3rd data frame. Required: all outputs 0 next cycle. A fresh packet C=0xFFFFFFFF, CTL=0x7F decodes correctly with no proto_err.
6. Streaming: 3 packets back-to-back with zero idle cycles, including one single-ctl packet in the middle. Required: 3 out_valid pulses, spaced 55, 11, 55 cycles apart, with correct data each.
